fp_mul_pipe: RTL and testbench

//   Parametrised, pipelined floating-point multiplier. Default config is bf16.

---
 rtl/fp_pkg.sv | 14 +
 rtl/fp_classify.sv | 33 +++
 rtl/fp_mul_pipe.sv | 173 +++++++++++++++++
 tb/tb_fp_mul_pipe.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared floating-point definitions: one-hot class flag bit positions and the
// exponent bias for a given exponent field width.
package fp_pkg;

   localparam int FLAG_NAN  = 3;
   localparam int FLAG_ZERO = 2;
   localparam int FLAG_INF  = 1;
   localparam int FLAG_NORM = 0;

   function automatic int fp_bias(input int exp_width);
      return (1 << (exp_width - 1)) - 1;
   endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational unpack of one IEEE-style operand into sign/exp/sig and a
// one-hot class flag. Subnormals (exp=0) are reported as ZERO.
module fp_classify
   import fp_pkg::*;
#(
   parameter int EXP_WIDTH  = 8,
   parameter int SIG_WIDTH  = 7,
   parameter int FLAG_WIDTH = 4
) (
   input  logic [EXP_WIDTH+SIG_WIDTH:0] i_data,
   output logic                         o_sign,
   output logic [EXP_WIDTH-1:0]         o_exp,
   output logic [SIG_WIDTH-1:0]         o_sig,
   output logic [FLAG_WIDTH-1:0]        o_flag
);

   assign o_sign = i_data[EXP_WIDTH+SIG_WIDTH];
   assign o_exp  = i_data[EXP_WIDTH+SIG_WIDTH-1 -: EXP_WIDTH];
   assign o_sig  = i_data[SIG_WIDTH-1:0];

   always_comb begin
      o_flag = '0;
      if (o_exp == '0) begin
         o_flag[FLAG_ZERO] = 1'b1;
      end else if (&o_exp) begin
         if (o_sig == '0) o_flag[FLAG_INF] = 1'b1;
         else             o_flag[FLAG_NAN] = 1'b1;
      end else begin
         o_flag[FLAG_NORM] = 1'b1;
      end
   end

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined floating-point multiplier (bf16 by default) with
// round-to-nearest-even, overflow/underflow saturation and valid/ready stream.
module fp_mul_pipe
   import fp_pkg::*;
#(
   parameter int EXP_WIDTH  = 8,
   parameter int SIG_WIDTH  = 7,
   parameter int FLAG_WIDTH = 4,
   parameter int TAG_WIDTH  = 4
) (
   input  logic                            i_clk,
   input  logic                            i_rst_n,
   input  logic                            i_valid,
   output logic                            o_ready,
   input  logic [EXP_WIDTH+SIG_WIDTH:0]    i_data_a,
   input  logic [EXP_WIDTH+SIG_WIDTH:0]    i_data_b,
   input  logic [TAG_WIDTH-1:0]            i_tag,
   output logic                            o_valid,
   input  logic                            i_ready,
   output logic [EXP_WIDTH+SIG_WIDTH:0]    o_data,
   output logic [FLAG_WIDTH-1:0]           o_flag,
   output logic [TAG_WIDTH-1:0]            o_tag
);

   localparam int W   = 1 + EXP_WIDTH + SIG_WIDTH;
   localparam int EW2 = EXP_WIDTH + 2;
   localparam int MW  = SIG_WIDTH + 1;
   localparam int PW  = 2 * MW;
   localparam logic signed [EW2-1:0] BIAS_S    = EW2'(fp_bias(EXP_WIDTH));
   localparam logic signed [EW2-1:0] EXP_MAX_S = EW2'((1 << EXP_WIDTH) - 1);

   logic                  sign_a, sign_b;
   logic [EXP_WIDTH-1:0]  exp_a, exp_b;
   logic [SIG_WIDTH-1:0]  sig_a, sig_b;
   logic [FLAG_WIDTH-1:0] flag_a, flag_b;

   fp_classify #(.EXP_WIDTH(EXP_WIDTH), .SIG_WIDTH(SIG_WIDTH), .FLAG_WIDTH(FLAG_WIDTH)) u_cls_a (
      .i_data(i_data_a), .o_sign(sign_a), .o_exp(exp_a), .o_sig(sig_a), .o_flag(flag_a));
   fp_classify #(.EXP_WIDTH(EXP_WIDTH), .SIG_WIDTH(SIG_WIDTH), .FLAG_WIDTH(FLAG_WIDTH)) u_cls_b (
      .i_data(i_data_b), .o_sign(sign_b), .o_exp(exp_b), .o_sig(sig_b), .o_flag(flag_b));

   logic adv;

   // S1 state
   logic                  s1_valid_q, s1_valid_d, s1_sign_q, s1_sign_d, s1_spec_q, s1_spec_d;
   logic signed [EW2-1:0] s1_esum_q, s1_esum_d;
   logic [MW-1:0]         s1_man_a_q, s1_man_a_d, s1_man_b_q, s1_man_b_d;
   logic [FLAG_WIDTH-1:0] s1_flag_q, s1_flag_d;
   logic [W-1:0]          s1_data_q, s1_data_d;
   logic [TAG_WIDTH-1:0]  s1_tag_q, s1_tag_d;
   // S2 state
   logic                  s2_valid_q, s2_valid_d, s2_sign_q, s2_sign_d, s2_spec_q, s2_spec_d;
   logic signed [EW2-1:0] s2_esum_q, s2_esum_d;
   logic [PW-1:0]         s2_prod_q, s2_prod_d;
   logic [FLAG_WIDTH-1:0] s2_flag_q, s2_flag_d;
   logic [W-1:0]          s2_data_q, s2_data_d;
   logic [TAG_WIDTH-1:0]  s2_tag_q, s2_tag_d;
   // S3 / output state
   logic                  out_valid_q, out_valid_d;
   logic [W-1:0]          out_data_q, out_data_d;
   logic [FLAG_WIDTH-1:0] out_flag_q, out_flag_d;
   logic [TAG_WIDTH-1:0]  out_tag_q, out_tag_d;

   // S3 combinational intermediates
   logic                  prod_msb, guard, sticky, rnd;
   logic [SIG_WIDTH-1:0]  frac;
   logic [SIG_WIDTH:0]    frac_r;
   logic signed [EW2-1:0] exp_f;

   assign adv     = ~out_valid_q | i_ready;
   assign o_ready = adv;
   assign o_valid = out_valid_q;
   assign o_data  = out_data_q;
   assign o_flag  = out_flag_q;
   assign o_tag   = out_tag_q;

   always_comb begin
      s1_valid_d = s1_valid_q; s1_sign_d = s1_sign_q; s1_spec_d = s1_spec_q;
      s1_esum_d  = s1_esum_q;  s1_man_a_d = s1_man_a_q; s1_man_b_d = s1_man_b_q;
      s1_flag_d  = s1_flag_q;  s1_data_d = s1_data_q; s1_tag_d = s1_tag_q;
      if (adv) begin
         s1_valid_d = i_valid;
         s1_tag_d   = i_tag;
         s1_sign_d  = sign_a ^ sign_b;
         s1_esum_d  = EW2'(exp_a) + EW2'(exp_b);
         s1_man_a_d = {1'b1, sig_a};
         s1_man_b_d = {1'b1, sig_b};
         s1_spec_d  = 1'b1;
         s1_flag_d  = '0;
         s1_data_d  = '0;
         // NaN wins, then 0*inf (also NaN), then zero, then infinity.
         if (flag_a[FLAG_NAN] | flag_b[FLAG_NAN] | (flag_a[FLAG_ZERO] & flag_b[FLAG_INF]) |
             (flag_a[FLAG_INF] & flag_b[FLAG_ZERO])) begin
            s1_flag_d[FLAG_NAN] = 1'b1;
            s1_data_d = {sign_a ^ sign_b, {EXP_WIDTH{1'b1}}, {SIG_WIDTH{1'b1}}};
         end else if (flag_a[FLAG_ZERO] | flag_b[FLAG_ZERO]) begin
            s1_flag_d[FLAG_ZERO] = 1'b1;
            s1_data_d = {sign_a ^ sign_b, {(W-1){1'b0}}};
         end else if (flag_a[FLAG_INF] | flag_b[FLAG_INF]) begin
            s1_flag_d[FLAG_INF] = 1'b1;
            s1_data_d = {sign_a ^ sign_b, {EXP_WIDTH{1'b1}}, {SIG_WIDTH{1'b0}}};
         end else begin
            s1_spec_d = 1'b0;
         end
      end
   end

   always_comb begin
      s2_valid_d = s2_valid_q; s2_sign_d = s2_sign_q; s2_spec_d = s2_spec_q;
      s2_esum_d  = s2_esum_q;  s2_prod_d = s2_prod_q; s2_flag_d = s2_flag_q;
      s2_data_d  = s2_data_q;  s2_tag_d  = s2_tag_q;
      if (adv) begin
         s2_valid_d = s1_valid_q; s2_sign_d = s1_sign_q; s2_spec_d = s1_spec_q;
         s2_esum_d  = s1_esum_q;  s2_flag_d = s1_flag_q; s2_data_d = s1_data_q;
         s2_tag_d   = s1_tag_q;
         s2_prod_d  = PW'(s1_man_a_q) * PW'(s1_man_b_q);
      end
   end

   always_comb begin
      prod_msb = s2_prod_q[PW-1];
      frac     = prod_msb ? s2_prod_q[PW-2 -: SIG_WIDTH] : s2_prod_q[PW-3 -: SIG_WIDTH];
      guard    = prod_msb ? s2_prod_q[PW-2-SIG_WIDTH] : s2_prod_q[PW-3-SIG_WIDTH];
      sticky   = prod_msb ? (|s2_prod_q[PW-3-SIG_WIDTH:0]) : (|s2_prod_q[PW-4-SIG_WIDTH:0]);
      rnd      = guard & (sticky | frac[0]);
      // A carry out of the rounded fraction leaves the low bits at zero, which
      // is already the correctly re-normalised fraction.
      frac_r   = {1'b0, frac} + (SIG_WIDTH+1)'(rnd);
      exp_f    = s2_esum_q + EW2'(prod_msb) + EW2'(frac_r[SIG_WIDTH]) - BIAS_S;

      out_valid_d = out_valid_q; out_data_d = out_data_q;
      out_flag_d  = out_flag_q;  out_tag_d  = out_tag_q;
      if (adv) begin
         out_valid_d = s2_valid_q;
         out_tag_d   = s2_tag_q;
         out_flag_d  = '0;
         if (s2_spec_q) begin
            out_flag_d = s2_flag_q;
            out_data_d = s2_data_q;
         end else if (exp_f >= EXP_MAX_S) begin
            out_flag_d[FLAG_INF] = 1'b1;
            out_data_d = {s2_sign_q, {EXP_WIDTH{1'b1}}, {SIG_WIDTH{1'b0}}};
         end else if (exp_f[EW2-1] || (exp_f == '0)) begin
            out_flag_d[FLAG_ZERO] = 1'b1;
            out_data_d = {s2_sign_q, {(W-1){1'b0}}};
         end else begin
            out_flag_d[FLAG_NORM] = 1'b1;
            out_data_d = {s2_sign_q, exp_f[EXP_WIDTH-1:0], frac_r[SIG_WIDTH-1:0]};
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         s1_valid_q <= 1'b0; s1_sign_q <= 1'b0; s1_spec_q <= 1'b0; s1_esum_q <= '0;
         s1_man_a_q <= '0;   s1_man_b_q <= '0;  s1_flag_q <= '0;   s1_data_q <= '0;
         s1_tag_q   <= '0;
         s2_valid_q <= 1'b0; s2_sign_q <= 1'b0; s2_spec_q <= 1'b0; s2_esum_q <= '0;
         s2_prod_q  <= '0;   s2_flag_q <= '0;   s2_data_q <= '0;   s2_tag_q  <= '0;
         out_valid_q <= 1'b0; out_data_q <= '0; out_flag_q <= '0;  out_tag_q <= '0;
      end else begin
         s1_valid_q <= s1_valid_d; s1_sign_q <= s1_sign_d; s1_spec_q <= s1_spec_d;
         s1_esum_q  <= s1_esum_d;  s1_man_a_q <= s1_man_a_d; s1_man_b_q <= s1_man_b_d;
         s1_flag_q  <= s1_flag_d;  s1_data_q <= s1_data_d; s1_tag_q <= s1_tag_d;
         s2_valid_q <= s2_valid_d; s2_sign_q <= s2_sign_d; s2_spec_q <= s2_spec_d;
         s2_esum_q  <= s2_esum_d;  s2_prod_q <= s2_prod_d; s2_flag_q <= s2_flag_d;
         s2_data_q  <= s2_data_d;  s2_tag_q  <= s2_tag_d;
         out_valid_q <= out_valid_d; out_data_q <= out_data_d;
         out_flag_q  <= out_flag_d;  out_tag_q  <= out_tag_d;
      end
   end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Self-checking bench for fp_mul_pipe (bf16): directed vectors, stall, reset
// and randomized traffic against an integer-arithmetic reference model.
module tb_fp_mul_pipe;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_valid = 1'b0, i_ready = 1'b1;
   logic [15:0] i_data_a = '0, i_data_b = '0;
   logic [3:0]  i_tag = '0;
   logic        o_ready, o_valid;
   logic [15:0] o_data;
   logic [3:0]  o_flag, o_tag;

   int checks = 0;
   int errors = 0;
   logic [23:0] exp_q[$];   // {tag, flag, data}
   logic        last_ovalid;
   logic        acc;

   fp_mul_pipe dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
      .i_data_a(i_data_a), .i_data_b(i_data_b), .i_tag(i_tag),
      .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_flag(o_flag), .o_tag(o_tag));

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", name, obs, expv);
      end
   endtask

   // Reference: exact integer product of the 8-bit mantissas, rounded to 8
   // significant bits with ties-to-even, exponent from the product's bit length.
   function automatic logic [19:0] model(input logic [15:0] a, input logic [15:0] b);
      int ea, eb, fa, fb, p, n, sh, q, r, half, e;
      logic s, an, bn, ai, bi, az, bz;
      s  = a[15] ^ b[15];
      ea = int'(a[14:7]); eb = int'(b[14:7]);
      fa = int'(a[6:0]);  fb = int'(b[6:0]);
      an = (ea == 255) && (fa != 0); bn = (eb == 255) && (fb != 0);
      ai = (ea == 255) && (fa == 0); bi = (eb == 255) && (fb == 0);
      az = (ea == 0);                bz = (eb == 0);
      if (an || bn || (az && bi) || (ai && bz)) return {4'b1000, s, 8'hFF, 7'h7F};
      if (az || bz) return {4'b0100, s, 15'h0};
      if (ai || bi) return {4'b0010, s, 8'hFF, 7'h00};
      p  = (128 + fa) * (128 + fb);
      n  = (p >= 32768) ? 15 : 14;
      sh = n - 7;
      q  = p >> sh;
      r  = p - (q << sh);
      half = 1 << (sh - 1);
      if (r > half || (r == half && (q % 2) == 1)) q++;
      if (q == 256) begin q = 128; n++; end
      e = ea + eb - 127 + (n - 14);
      if (e >= 255) return {4'b0010, s, 8'hFF, 7'h00};
      if (e <= 0)   return {4'b0100, s, 15'h0};
      return {4'b0001, s, e[7:0], q[6:0]};
   endfunction

   function automatic logic [15:0] rand_op();
      logic [15:0] specials [6];
      logic [15:0] v;
      specials = '{16'h0000, 16'h8000, 16'h7F80, 16'hFF80, 16'h7FC1, 16'h0012};
      case ($urandom_range(0, 9))
         0:       v = specials[$urandom_range(0, 5)];
         1:       v = {1'($urandom), 8'($urandom_range(1, 254)), 7'($urandom)};
         default: v = {1'($urandom), 8'($urandom_range(70, 185)), 7'($urandom)};
      endcase
      return v;
   endfunction

   // One clock cycle: drive inputs, sample mid-cycle, score any output.
   task automatic step(input logic v, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] t, input logic rdy, output logic accepted);
      logic [23:0] e;
      i_valid = v; i_data_a = a; i_data_b = b; i_tag = t; i_ready = rdy;
      #4;
      last_ovalid = o_valid;
      check("o_ready", {31'b0, o_ready}, {31'b0, (!o_valid || rdy)});
      if (o_valid) begin
         if (exp_q.size() == 0) begin
            check("unexpected_valid", {31'b0, o_valid}, 32'd0);
         end else begin
            e = exp_q[0];
            check("o_data", {16'b0, o_data}, {16'b0, e[15:0]});
            check("o_flag", {28'b0, o_flag}, {28'b0, e[19:16]});
            check("o_tag",  {28'b0, o_tag},  {28'b0, e[23:20]});
            if (rdy) void'(exp_q.pop_front());
         end
      end
      accepted = v && o_ready;
      if (accepted) exp_q.push_back({t, model(a, b)});
      @(posedge clk); #1;
   endtask

   task automatic drain();
      for (int k = 0; k < 30 && exp_q.size() != 0; k++) step(1'b0, 16'h0, 16'h0, 4'h0, 1'b1, acc);
      check("drain_empty", exp_q.size(), 32'd0);
   endtask

   task automatic directed(input logic [15:0] a, input logic [15:0] b, input logic [3:0] t,
                           input logic [15:0] want_data, input logic [3:0] want_flag);
      logic [19:0] m;
      m = model(a, b);
      check("model_vs_table", {12'b0, m}, {12'b0, want_flag, want_data});
      step(1'b1, a, b, t, 1'b1, acc);
   endtask

   initial begin
      int pushed;
      logic [15:0] ra, rb;
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_o_valid", {31'b0, o_valid}, 32'd0);
      check("rst_o_data",  {16'b0, o_data}, 32'd0);
      check("rst_o_flag",  {28'b0, o_flag}, 32'd0);
      check("rst_o_tag",   {28'b0, o_tag},  32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Latency: first item shows up on the third cycle after acceptance
      step(1'b1, 16'h3F80, 16'h4000, 4'd5, 1'b1, acc);
      check("accept_first", {31'b0, acc}, 32'd1);
      step(1'b0, 16'h0, 16'h0, 4'h0, 1'b1, acc);
      check("lat_c1", {31'b0, last_ovalid}, 32'd0);
      step(1'b0, 16'h0, 16'h0, 4'h0, 1'b1, acc);
      check("lat_c2", {31'b0, last_ovalid}, 32'd0);
      step(1'b0, 16'h0, 16'h0, 4'h0, 1'b1, acc);
      check("lat_c3", {31'b0, last_ovalid}, 32'd1);
      drain();

      // Directed arithmetic and special cases, back to back
      directed(16'h3FC0, 16'h3FC0, 4'd1, 16'h4010, 4'b0001);
      directed(16'h3FC1, 16'h3FC1, 4'd2, 16'h4012, 4'b0001);
      directed(16'h3FFF, 16'h3FFF, 4'd3, 16'h407E, 4'b0001);
      directed(16'h7F80, 16'h0000, 4'd4, 16'h7FFF, 4'b1000);
      directed(16'hFF80, 16'h4000, 4'd6, 16'hFF80, 4'b0010);
      directed(16'h7FC1, 16'h3F80, 4'd7, 16'h7FFF, 4'b1000);
      directed(16'h7F00, 16'h4000, 4'd8, 16'h7F80, 4'b0010);
      directed(16'h0080, 16'h3F00, 4'd9, 16'h0000, 4'b0100);
      drain();

      // Six-item stream with i_ready low for 4 cycles mid-stream
      pushed = 0;
      for (int c = 0; c < 40 && (pushed < 6 || exp_q.size() != 0); c++) begin
         ra = rand_op(); rb = rand_op();
         step(pushed < 6, ra, rb, 4'(pushed + 10), !(c >= 4 && c < 8), acc);
         if (acc) pushed++;
      end
      check("stream_pushed", pushed, 32'd6);
      drain();

      // Reset with three items in flight
      for (int k = 0; k < 3; k++) step(1'b1, rand_op(), rand_op(), 4'(k + 1), 1'b1, acc);
      rst_n = 1'b0;
      #1;
      check("midrst_o_valid", {31'b0, o_valid}, 32'd0);
      check("midrst_o_data",  {16'b0, o_data}, 32'd0);
      exp_q.delete();
      i_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      step(1'b1, 16'h3F80, 16'h4000, 4'd12, 1'b1, acc);
      step(1'b0, 16'h0, 16'h0, 4'h0, 1'b1, acc);
      check("postrst_c1", {31'b0, last_ovalid}, 32'd0);
      step(1'b0, 16'h0, 16'h0, 4'h0, 1'b1, acc);
      check("postrst_c2", {31'b0, last_ovalid}, 32'd0);
      step(1'b0, 16'h0, 16'h0, 4'h0, 1'b1, acc);
      check("postrst_c3", {31'b0, last_ovalid}, 32'd1);
      drain();

      // Randomized traffic with random backpressure
      for (int k = 0; k < 300; k++)
         step($urandom_range(0, 3) != 0, rand_op(), rand_op(), 4'($urandom),
              $urandom_range(0, 3) != 0, acc);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
